// File: rtl/uimac_tx_pfc_ctrl_if.sv
// Control-frame interface for uimac_tx_pfc_ctrl.
//   mac_ctrl_valid/mac_data : control-frame body bytes from MAC RX extraction
//   pause_active            : per-class throttle vector to the MAC TX scheduler
//   pause_req/pfc_frame     : 1-cycle pulses on a committed PAUSE/PFC frame
//   pause_time              : last committed pause time in clock cycles
//   frame_err               : 1-cycle pulse when a frame is truncated
// master = frame source / pause consumer, slave = the control-frame processor.
interface uimac_tx_pfc_ctrl_if #(
  parameter int NUM_CLASS = 8,
  parameter int TIMER_W   = 22
);
  logic                 mac_ctrl_valid;
  logic [7:0]           mac_data;
  logic [NUM_CLASS-1:0] pause_active;
  logic                 pause_req;
  logic [TIMER_W-1:0]   pause_time;
  logic                 pfc_frame;
  logic                 frame_err;

  modport master (
    output mac_ctrl_valid, mac_data,
    input  pause_active, pause_req, pause_time, pfc_frame, frame_err
  );

  modport slave (
    input  mac_ctrl_valid, mac_data,
    output pause_active, pause_req, pause_time, pfc_frame, frame_err
  );
endinterface

// File: rtl/uimac_tx_pfc_ctrl.sv
// MAC control-frame processor: parses IEEE 802.3x PAUSE (opcode 0x0001) and
// 802.1Qbb PFC (opcode 0x0101) frame bodies and runs one pause countdown
// timer per priority class.
// Ports:
//   I_clk     : system clock
//   I_reset_n : synchronous reset, active low
//   mac       : slave side of uimac_tx_pfc_ctrl_if (frame bytes in,
//               pause_active/pause_req/pause_time/pfc_frame/frame_err out)
module uimac_tx_pfc_ctrl #(
  parameter int NUM_CLASS    = 8,
  parameter int QUANTA_SHIFT = 6,
  parameter int PAUSE_EN     = 1,
  parameter int PFC_EN       = 1,
  parameter int TIMER_W      = 16 + QUANTA_SHIFT
) (
  input  logic                  I_clk,
  input  logic                  I_reset_n,
  uimac_tx_pfc_ctrl_if.slave    mac
);

  typedef enum logic [1:0] {IDLE, PARSE, DROP} state_t;

  state_t               state_q, state_d;
  logic [4:0]           cnt_q;
  logic [7:0]           op_hi_q;
  logic                 pfc_q;
  logic [7:0]           en_q;
  logic [7:0]           hi_q;
  logic [15:0]          q_q   [8];
  logic [15:0]          q_eff [8];
  logic [TIMER_W-1:0]   timer_q [NUM_CLASS];
  logic [TIMER_W-1:0]   timer_d [NUM_CLASS];
  logic [TIMER_W-1:0]   time_q;
  logic                 req_q, pfc_frame_q, err_q;

  logic                 valid;
  logic [15:0]          opcode;
  logic                 op_pause, op_pfc;
  logic                 commit, err;
  logic [4:0]           q_off;
  logic [2:0]           q_idx;
  logic [TIMER_W-1:0]   pause_val;

  assign valid    = mac.mac_ctrl_valid;
  assign opcode   = {op_hi_q, mac.mac_data};
  assign op_pause = (PAUSE_EN != 0) && (opcode == 16'h0001);
  assign op_pfc   = (PFC_EN != 0)   && (opcode == 16'h0101);
  // PFC quanta bytes: k4+2i (high), k5+2i (low) -> class index from k-5
  assign q_off    = cnt_q - 5'd5;
  assign q_idx    = q_off[3:1];
  assign pause_val = TIMER_W'({hi_q, mac.mac_data}) << QUANTA_SHIFT;

  // The last PFC quanta (class 7) is still on the bus at commit time.
  always_comb begin
    q_eff    = q_q;
    q_eff[7] = {hi_q, mac.mac_data};
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) state_q <= IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      IDLE: if (valid) state_d = PARSE;
      PARSE: begin
        if (!valid) begin
          err     = 1'b1;
          state_d = IDLE;
        end else if (cnt_q == 5'd1) begin
          if (!op_pause && !op_pfc) state_d = DROP;
        end else if ((!pfc_q && cnt_q == 5'd3) || (pfc_q && cnt_q == 5'd19)) begin
          commit  = 1'b1;
          state_d = DROP;
        end
      end
      DROP: if (!valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load wins over decrement; unenabled PFC classes keep counting.
  always_comb begin
    for (int unsigned i = 0; i < NUM_CLASS; i++) begin
      timer_d[i] = (timer_q[i] != '0) ? timer_q[i] - TIMER_W'(1) : '0;
      if (commit) begin
        if (!pfc_q)       timer_d[i] = pause_val;
        else if (en_q[i]) timer_d[i] = TIMER_W'(q_eff[i]) << QUANTA_SHIFT;
      end
    end
  end

  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      cnt_q       <= '0;
      op_hi_q     <= '0;
      pfc_q       <= 1'b0;
      en_q        <= '0;
      hi_q        <= '0;
      time_q      <= '0;
      req_q       <= 1'b0;
      pfc_frame_q <= 1'b0;
      err_q       <= 1'b0;
      for (int unsigned i = 0; i < 8; i++)         q_q[i]     <= '0;
      for (int unsigned i = 0; i < NUM_CLASS; i++) timer_q[i] <= '0;
    end else begin
      req_q       <= commit;
      pfc_frame_q <= commit && pfc_q;
      err_q       <= err;
      timer_q     <= timer_d;

      if (state_q == IDLE)                 cnt_q <= valid ? 5'd1 : 5'd0;
      else if (valid && cnt_q != 5'd31)    cnt_q <= cnt_q + 5'd1;

      if (state_q == IDLE && valid) op_hi_q <= mac.mac_data;

      if (state_q == PARSE && valid) begin
        if (cnt_q == 5'd1) pfc_q <= op_pfc;
        if (cnt_q == 5'd3) en_q  <= mac.mac_data;
        if (!cnt_q[0])          hi_q       <= mac.mac_data;
        else if (cnt_q >= 5'd5) q_q[q_idx] <= {hi_q, mac.mac_data};
      end

      if (commit)
        time_q <= pfc_q ? (TIMER_W'(q_eff[0]) << QUANTA_SHIFT) : pause_val;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_CLASS; i++)
      mac.pause_active[i] = (timer_q[i] != '0);
  end

  assign mac.pause_req  = req_q;
  assign mac.pfc_frame  = pfc_frame_q;
  assign mac.frame_err  = err_q;
  assign mac.pause_time = time_q;

endmodule
